// File: rtl/cordic_iter_hs.sv
// cordic_iter_hs -- iterative CORDIC engine with valid/ready on both sides.
//
// One transaction per accept: mode_i selects rotate (0) or vector (1).
// Rotate drives z to zero and returns K-scaled (x,y) rotated by theta_i.
// Vector drives y to zero and returns K*|(x,y)| in x_o and theta_i+atan2(y,x)
// in theta_o. A quadrant pre-rotation on load extends convergence to the full
// circle. One micro-rotation per clock, ITER clocks per transaction. Gain K is
// not corrected.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; mode_i, x_i, y_i, theta_i sampled on accept
//   out_valid/out_ready output handshake; x_o, y_o, theta_o held while stalled
//   dbg_state           current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both 1. in_ready is 1 only in IDLE, out_valid is 1 only in DONE,
// neither depends combinationally on the other side, and the output payload
// is stable for as long as out_valid is 1.
module cordic_iter_hs #(
    parameter int XY_W    = 17,
    parameter int ANGLE_W = 19,
    parameter int FRAC    = 15,
    parameter int ITER    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode_i,
    input  logic [XY_W-1:0]    x_i,
    input  logic [XY_W-1:0]    y_i,
    input  logic [ANGLE_W-1:0] theta_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XY_W-1:0]    x_o,
    output logic [XY_W-1:0]    y_o,
    output logic [ANGLE_W-1:0] theta_o,
    output logic [1:0]         dbg_state
);
    // Two guard bits: CORDIC gain (<1.65) plus pre-rotation never overflow.
    localparam int W     = XY_W + 2;
    localparam int CW    = $clog2(ITER + 1);
    localparam int TAB_N = 2 ** CW;
    // Fixed-point scale used while building the angle constants.
    localparam int SCL   = 40;

    // atan(1/n) scaled by 2^SCL, Taylor series in integers.
    function automatic longint atan_inv(input longint n);
        longint term;
        longint sum;
        longint n2;
        longint div;
        logic   neg;
        term = (64'd1 <<< SCL) / n;
        n2   = n * n;
        sum  = 64'd0;
        div  = 64'd1;
        neg  = 1'b0;
        while (term != 64'd0) begin
            if (neg) sum = sum - term / div;
            else     sum = sum + term / div;
            term = term / n2;
            div  = div + 64'd2;
            neg  = ~neg;
        end
        return sum;
    endfunction

    // atan(2^-i) scaled by 2^SCL; atan(1) = atan(1/2) + atan(1/3).
    function automatic longint atan_pow2(input int i);
        if (i == 0) return atan_inv(64'd2) + atan_inv(64'd3);
        return atan_inv(64'd1 <<< i);
    endfunction

    function automatic int to_frac(input longint v);
        return int'((v + (64'd1 <<< (SCL - FRAC - 1))) >>> (SCL - FRAC));
    endfunction

    function automatic int atan_const(input int i);
        if (i >= ITER) return 0;
        return to_frac(atan_pow2(i));
    endfunction

    // pi/2 = 2*atan(1)
    localparam int HALF_PI = to_frac(atan_pow2(0) <<< 1);
    localparam logic signed [W-1:0] H = W'(HALF_PI);

    function automatic logic [XY_W-1:0] sat(input logic signed [W-1:0] v);
        if (v[W-1:XY_W-1] == {(W-XY_W+1){v[W-1]}}) return v[XY_W-1:0];
        if (v[W-1]) return {1'b1, {(XY_W-1){1'b0}}};
        return {1'b0, {(XY_W-1){1'b1}}};
    endfunction

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nxt;

    logic signed [W-1:0] x_r, y_r, z_r;
    logic [CW-1:0]       cnt;
    logic                mode_r;

    // Angle table, one entry per iteration; entries past ITER-1 are zero.
    logic signed [W-1:0] atan_tab [TAB_N];
    for (genvar g = 0; g < TAB_N; g++) begin : g_atan
        localparam int AV = atan_const(g);
        assign atan_tab[g] = W'(AV);
    end

    // Sign-extended inputs and quadrant pre-rotation.
    logic signed [W-1:0] x_ext, y_ext, z_ext;
    logic signed [W-1:0] x_pre, y_pre, z_pre;
    assign x_ext = W'($signed(x_i));
    assign y_ext = W'($signed(y_i));
    assign z_ext = W'($signed(theta_i));

    always_comb begin
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = z_ext;
        if (!mode_i) begin
            // Rotate: bring |z| back within pi/2 by a quarter turn.
            if (z_ext > H) begin
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = z_ext - H;
            end else if (z_ext < -H) begin
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = z_ext + H;
            end
        end else if (x_ext[W-1]) begin
            // Vector: move a left-half-plane vector into the right half.
            if (!y_ext[W-1]) begin
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = z_ext + H;
            end else begin
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = z_ext - H;
            end
        end
    end

    // One micro-rotation from the current register values.
    logic signed [W-1:0] x_sh, y_sh, atan_cur;
    logic signed [W-1:0] x_it, y_it, z_it;
    logic                d_pos;
    logic                last_iter;

    always_comb begin
        x_sh     = x_r >>> cnt;
        y_sh     = y_r >>> cnt;
        atan_cur = atan_tab[cnt];
        d_pos    = mode_r ? y_r[W-1] : ~z_r[W-1];
        if (d_pos) begin
            x_it = x_r - y_sh;
            y_it = y_r + x_sh;
            z_it = z_r - atan_cur;
        end else begin
            x_it = x_r + y_sh;
            y_it = y_r - x_sh;
            z_it = z_r + atan_cur;
        end
    end

    assign last_iter = (cnt == CW'(ITER - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            cnt     <= '0;
            mode_r  <= 1'b0;
            x_o     <= '0;
            y_o     <= '0;
            theta_o <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_r <= mode_i;
                        x_r    <= x_pre;
                        y_r    <= y_pre;
                        z_r    <= z_pre;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    x_r <= x_it;
                    y_r <= y_it;
                    z_r <= z_it;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        x_o     <= sat(x_it);
                        y_o     <= sat(y_it);
                        theta_o <= ANGLE_W'(z_it);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_cordic_iter_hs.sv
// Bench for cordic_iter_hs: directed quadrant/boundary cases, saturation,
// backpressure, mid-run reset, and randomized rotate/vector transactions
// checked against a floating-point trigonometric reference.
module tb_cordic_iter_hs;

    localparam int  ITER = 16;
    localparam real ONE  = 32768.0;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        mode_i;
    logic [16:0] x_i;
    logic [16:0] y_i;
    logic [18:0] theta_i;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] x_o;
    logic [16:0] y_o;
    logic [18:0] theta_o;
    logic [1:0]  dbg_state;

    int  total = 0;
    int  bad   = 0;
    real k_gain;

    cordic_iter_hs #(
        .XY_W(17), .ANGLE_W(19), .FRAC(15), .ITER(ITER)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .mode_i(mode_i),
        .x_i(x_i), .y_i(y_i), .theta_i(theta_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_o(x_o), .y_o(y_o), .theta_o(theta_o),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checkers ----------------
    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input real exp, input int tol);
        real diff;
        diff = real'(obs) - exp;
        if (diff < 0.0) diff = -diff;
        total++;
        assert ((diff <= real'(tol)) === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0.1f tol=%0d", tag, obs, exp, tol);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real ref_rot_x(input int x, input int y, input int th);
        real a;
        a = real'(th) / ONE;
        return k_gain * (real'(x) * $cos(a) - real'(y) * $sin(a));
    endfunction

    function automatic real ref_rot_y(input int x, input int y, input int th);
        real a;
        a = real'(th) / ONE;
        return k_gain * (real'(x) * $sin(a) + real'(y) * $cos(a));
    endfunction

    function automatic real ref_mag(input int x, input int y);
        return k_gain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    endfunction

    function automatic real ref_ang(input int x, input int y, input int th);
        return real'(th) + $atan2(real'(y), real'(x)) * ONE;
    endfunction

    // ---------------- driver ----------------
    task automatic scramble_inputs();
        x_i     = 17'($urandom);
        y_i     = 17'($urandom);
        theta_i = 19'($urandom);
        mode_i  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, " ready_before_accept"}, int'(in_ready), 1);
    endtask

    // Full transaction: accept, measure latency, optionally stall the output
    // side for 'stall' cycles, then complete the output handshake.
    task automatic run_txn(input string tag, input logic mode, input int x, input int y,
                           input int th, input int stall,
                           output int xo, output int yo, output int to);
        int lat;
        wait_ready(tag);
        mode_i   = mode;
        x_i      = 17'(x);
        y_i      = 17'(y);
        theta_i  = 19'(th);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        check_eq({tag, " busy_ready"}, int'(in_ready), 0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, " latency"}, lat, ITER);
        xo = $signed(x_o);
        yo = $signed(y_o);
        to = $signed(theta_o);
        for (int c = 0; c < stall; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            scramble_inputs();
            @(posedge clk); #1;
            check_eq({tag, " stall_in_ready"},  int'(in_ready), 0);
            check_eq({tag, " stall_out_valid"}, int'(out_valid), 1);
            check_eq({tag, " stall_x_hold"},     $signed(x_o), xo);
            check_eq({tag, " stall_y_hold"},     $signed(y_o), yo);
            check_eq({tag, " stall_theta_hold"}, $signed(theta_o), to);
        end
        // Offer a new input on the release edge; it must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        scramble_inputs();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq({tag, " release_in_ready"},  int'(in_ready), 1);
        check_eq({tag, " release_out_valid"}, int'(out_valid), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int xo, yo, to;
        int x, y, th;
        string tag;

        k_gain = 1.0;
        for (int i = 0; i < ITER; i++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2 * i));

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode_i    = 1'b0;
        x_i       = '0;
        y_i       = '0;
        theta_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset in_ready",  int'(in_ready), 1);
        check_eq("reset out_valid", int'(out_valid), 0);
        check_eq("reset x_o",       $signed(x_o), 0);
        check_eq("reset y_o",       $signed(y_o), 0);
        check_eq("reset theta_o",   $signed(theta_o), 0);
        rst = 1'b0;

        // 30 deg rotate with 5-cycle output stall.
        run_txn("rot30", 1'b0, 19898, 0, 17157, 5, xo, yo, to);
        check_near("rot30 x_o", xo, 28377.0, 8);
        check_near("rot30 y_o", yo, 16384.0, 8);

        // Pre-rotation, both signs.
        run_txn("rot150", 1'b0, 19898, 0, 85786, 0, xo, yo, to);
        check_near("rot150 x_o", xo, -28377.0, 8);
        check_near("rot150 y_o", yo, 16384.0, 8);
        run_txn("rotm150", 1'b0, 19898, 0, -85786, 0, xo, yo, to);
        check_near("rotm150 x_o", xo, -28377.0, 8);
        check_near("rotm150 y_o", yo, -16384.0, 8);

        // Vector cases.
        run_txn("vec45", 1'b1, 23170, 23170, 0, 2, xo, yo, to);
        check_near("vec45 theta_o", to, 25736.0, 8);
        check_near("vec45 x_o", xo, 53963.0, 16);
        check_near("vec45 y_o", yo, 0.0, 8);
        run_txn("vec180", 1'b1, -32768, 0, 0, 0, xo, yo, to);
        check_near("vec180 theta_o", to, 102944.0, 8);
        run_txn("vecm90", 1'b1, 0, -32768, 0, 0, xo, yo, to);
        check_near("vecm90 theta_o", to, -51472.0, 8);

        // Out-of-range inputs: magnitude clamps to the 17-bit range.
        run_txn("sat_pos", 1'b1, 65535, 65535, 0, 0, xo, yo, to);
        check_eq("sat_pos x_o", xo, 65535);
        check_near("sat_pos theta_o", to, 25736.0, 16);
        run_txn("sat_neg", 1'b0, -65536, 0, 0, 0, xo, yo, to);
        check_eq("sat_neg x_o", xo, -65536);

        // Random rotate.
        for (int r = 0; r < 10; r++) begin
            x  = int'($urandom_range(0, 46000)) - 23000;
            y  = int'($urandom_range(0, 46000)) - 23000;
            th = int'($urandom_range(0, 205888)) - 102944;
            tag = $sformatf("rnd_rot%0d", r);
            run_txn(tag, 1'b0, x, y, th, int'($urandom_range(0, 3)), xo, yo, to);
            check_near({tag, " x_o"}, xo, ref_rot_x(x, y, th), 24);
            check_near({tag, " y_o"}, yo, ref_rot_y(x, y, th), 24);
            check_near({tag, " theta_o"}, to, 0.0, 8);
        end

        // Random vector, magnitude kept above ~0.37 so the angle is well defined.
        for (int r = 0; r < 10; r++) begin
            do begin
                x = int'($urandom_range(0, 46000)) - 23000;
                y = int'($urandom_range(0, 46000)) - 23000;
            end while (x * x + y * y < 144000000);
            th = int'($urandom_range(0, 40000)) - 20000;
            tag = $sformatf("rnd_vec%0d", r);
            run_txn(tag, 1'b1, x, y, th, int'($urandom_range(0, 3)), xo, yo, to);
            check_near({tag, " x_o"}, xo, ref_mag(x, y), 24);
            check_near({tag, " y_o"}, yo, 0.0, 16);
            check_near({tag, " theta_o"}, to, ref_ang(x, y, th), 24);
        end

        // Reset in the middle of RUN (iteration 7).
        wait_ready("midrst");
        mode_i   = 1'b0;
        x_i      = 17'd19898;
        y_i      = 17'd0;
        theta_i  = 19'd17157;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst out_valid", int'(out_valid), 0);
        check_eq("midrst in_ready",  int'(in_ready), 1);
        check_eq("midrst x_o",       $signed(x_o), 0);
        check_eq("midrst y_o",       $signed(y_o), 0);
        check_eq("midrst theta_o",   $signed(theta_o), 0);
        repeat (20) @(posedge clk);
        #1;
        check_eq("midrst no_late_result", int'(out_valid), 0);

        run_txn("rot30_after_rst", 1'b0, 19898, 0, 17157, 0, xo, yo, to);
        check_near("rot30_after_rst x_o", xo, 28377.0, 8);
        check_near("rot30_after_rst y_o", yo, 16384.0, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
